perm_engine: RTL
================

Name: perm_engine

Overview:
- Runtime-programmable bit-permutation unit, WIDTH bits wide. Successor to the fixed DES 32-bit P-box.
- The permutation table is loaded through a config port and resets to identity.
- Supports forward (gather) and inverse (scatter) mode, selectable per transfer.
- One registered stage with valid/ready on both sides. Sits after the S-box stage of the round datapath; also reused for the IP/FP and key-schedule permutations.

Parameters:
- WIDTH, 32, data width in bits; positions numbered 1..WIDTH, position 1 = MSB.
- IDX_W, 6, width of one table entry; must hold the value WIDTH.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  engine can accept input this cycle.
- in_data  input  WIDTH  word to permute; bit 1 = MSB.
- in_inv  input  1  0 = forward, 1 = inverse; sampled with in_data.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  permuted word.
- cfg_we  input  1  table write request.
- cfg_ready  output  1  table write is accepted this cycle.
- cfg_addr  input  IDX_W  table position, 1..WIDTH.
- cfg_data  input  IDX_W  source index for that position, 1..WIDTH.
- perm_ok  output  1  table is a bijection (see Optional Feature).
- chk_busy  output  1  bijection check in progress (see Optional Feature).

Behaviour:
- Reset:
  - tab[p] = p for all p (identity).
  - out_valid = 0, out_data = 0.
  - perm_ok = 1, chk_busy = 0.
  - Any in-flight result is discarded.
- Forward mode: out[p] = in[tab[p]].
  - If tab[p] is 0 or greater than WIDTH, out[p] = 0.
- Inverse mode: out[q] = OR of in[p] over all p with tab[p] == q.
  - A q with no such p gives 0.
  - For a bijective table this is the exact inverse permutation.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !cfg_we.
  - Input transfer occurs when in_valid && in_ready.
  - The result is registered in the same cycle as the transfer; latency 1. out_valid rises the next cycle.
  - out_data and out_valid are held stable while out_valid && !out_ready.
  - Simultaneous output drain and new input accept gives full throughput: 1 word/cycle.
  - If out_valid && out_ready && no new input, out_valid falls next cycle; out_data keeps its last value.
- Config:
  - cfg_ready = !out_valid.
  - Write occurs when cfg_we && cfg_ready; tab[cfg_addr] <= cfg_data.
  - A write to cfg_addr 0 or cfg_addr > WIDTH is ignored: the handshake completes, the table is unchanged.
  - cfg_we has priority over input: no input transfer in any cycle with cfg_we high.
  - A written entry is used by inputs accepted from the next cycle onward.
  - The table is only ever modified while the output stage is empty. A result never mixes old and new table contents.
- In-range cfg_data is not validated in hardware beyond the forward/inverse rules above.

Optional Feature:
- Macro: PERM_CHECK_EN.
- Defined:
  - Each accepted in-range write clears perm_ok and sets chk_busy the next cycle.
  - A scan counter then walks positions 1..WIDTH, one per cycle, marking a seen-bitmap bit per entry.
  - The result is flagged bad if any entry is out of range or already seen.
  - After WIDTH cycles, chk_busy = 0 and perm_ok = (no bad flags).
  - A new write during a scan restarts the scan from position 1.
  - Datapath is unaffected by the check.
- Not defined: perm_ok tied to 1, chk_busy tied to 0, no scan logic.

Test Plan:
- Identity after reset: rst 1 cycle; in_data = 0x80000001, in_inv = 0 -> next cycle out_valid = 1, out_data = 0x80000001.
- DES P table: load tab = {16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25}.
  - in 0x00010000 (bit 16), forward -> out 0x80000000.
  - in 0x80000000, inverse -> out 0x00010000.
- Back-pressure:
  - Stream 3 words with out_ready = 0 for 2 cycles -> in_ready = 0, out_data held.
  - Release out_ready -> words emerge in order, 1 per cycle, none lost or duplicated.
- Config vs data:
  - cfg_we while out_valid = 1 and out_ready = 0 -> cfg_ready = 0, table unchanged.
  - cfg_we with in_valid = 1 and out stage empty -> write accepted, in_ready = 0 that cycle.
- Out-of-range:
  - Write tab[1] = 0 -> forward in 0xFFFFFFFF gives out 0x7FFFFFFF.
  - Write to cfg_addr 33 -> no table change.
- PERM_CHECK_EN:
  - Identity then write tab[2] = 1 -> chk_busy = 1 for 32 cycles, then perm_ok = 0.
  - Write tab[2] = 2 -> after 32 cycles perm_ok = 1.
  - rst mid-scan -> perm_ok = 1, chk_busy = 0.

Source files
------------

// File: rtl/perm_engine.sv
// perm_engine: runtime-programmable WIDTH-bit permutation with forward/inverse modes, one registered stage.
// Optional table bijection checker enabled by defining PERM_CHECK_EN.
module perm_engine #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cfg_we,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [IDX_W-1:0] cfg_data,
    output logic             perm_ok,
    output logic             chk_busy
);

    // tab_q[i] holds the source index for position i+1 (position 1 = MSB).
    logic [IDX_W-1:0] tab_q [WIDTH];
    logic [IDX_W-1:0] tab_d [WIDTH];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;

    logic             in_fire;
    logic             cfg_fire;
    logic             cfg_hit;
    logic [WIDTH-1:0] fwd_word;
    logic [WIDTH-1:0] inv_word;

    assign in_ready  = (!out_valid_q || out_ready) && !cfg_we;
    assign cfg_ready = !out_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign cfg_fire  = cfg_we && cfg_ready;
    assign cfg_hit   = cfg_fire && (cfg_addr != '0) && (cfg_addr <= IDX_W'(WIDTH));

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Both directions share one match matrix: tab[p] == s links position p with source s.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        fwd_word = '0;
        inv_word = '0;
        for (int p = 0; p < WIDTH; p++) begin
            for (int s = 0; s < WIDTH; s++) begin
                if (tab_q[p] == IDX_W'(s + 1)) begin
                    fwd_word[WIDTH-1-p] = in_data[WIDTH-1-s];
                    inv_word[WIDTH-1-s] = inv_word[WIDTH-1-s] | in_data[WIDTH-1-p];
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = in_inv ? inv_word : fwd_word;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        tab_d = tab_q;
        if (cfg_hit) begin
            for (int p = 0; p < WIDTH; p++) begin
                if (cfg_addr == IDX_W'(p + 1)) begin
                    tab_d[p] = cfg_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            // NOTE: the table is a flop array, not a RAM macro, so it can be reset to identity.
            for (int p = 0; p < WIDTH; p++) begin
                tab_q[p] <= IDX_W'(p + 1);
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            tab_q       <= tab_d;
        end
    end

`ifdef PERM_CHECK_EN
    typedef enum logic {
        CHK_IDLE,
        CHK_SCAN
    } chk_state_e;

    chk_state_e       chk_state_q, chk_state_d;
    logic [IDX_W-1:0] scan_pos_q,  scan_pos_d;
    logic [WIDTH-1:0] seen_q,      seen_d;
    logic             bad_q,       bad_d;
    logic             perm_ok_q,   perm_ok_d;
    logic [IDX_W-1:0] scan_entry;
    logic             entry_bad;

    always_comb begin
        scan_entry = '0;
        for (int p = 0; p < WIDTH; p++) begin
            if (scan_pos_q == IDX_W'(p + 1)) begin
                scan_entry = tab_q[p];
            end
        end
        entry_bad = (scan_entry == '0) || (scan_entry > IDX_W'(WIDTH));
        for (int s = 0; s < WIDTH; s++) begin
            if ((scan_entry == IDX_W'(s + 1)) && seen_q[s]) begin
                entry_bad = 1'b1;
            end
        end
    end

    // A fresh in-range write always restarts the scan, even mid-walk.
    always_comb begin
        chk_state_d = chk_state_q;
        scan_pos_d  = scan_pos_q;
        seen_d      = seen_q;
        bad_d       = bad_q;
        perm_ok_d   = perm_ok_q;
        if (cfg_hit) begin
            chk_state_d = CHK_SCAN;
            scan_pos_d  = IDX_W'(1);
            seen_d      = '0;
            bad_d       = 1'b0;
            perm_ok_d   = 1'b0;
        end else if (chk_state_q == CHK_SCAN) begin
            for (int s = 0; s < WIDTH; s++) begin
                if (scan_entry == IDX_W'(s + 1)) begin
                    seen_d[s] = 1'b1;
                end
            end
            bad_d = bad_q | entry_bad;
            if (scan_pos_q == IDX_W'(WIDTH)) begin
                chk_state_d = CHK_IDLE;
                perm_ok_d   = !(bad_q | entry_bad);
            end else begin
                scan_pos_d = scan_pos_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_state_q <= CHK_IDLE;
            scan_pos_q  <= IDX_W'(1);
            seen_q      <= '0;
            bad_q       <= 1'b0;
            perm_ok_q   <= 1'b1;
        end else begin
            chk_state_q <= chk_state_d;
            scan_pos_q  <= scan_pos_d;
            seen_q      <= seen_d;
            bad_q       <= bad_d;
            perm_ok_q   <= perm_ok_d;
        end
    end

    assign perm_ok  = perm_ok_q;
    assign chk_busy = (chk_state_q == CHK_SCAN);
`else
    assign perm_ok  = 1'b1;
    assign chk_busy = 1'b0;
`endif

endmodule
